// File: rtl/control_pipeline.sv
// Control-side pipeline: carries the decoded control bundle through E/M/W,
// resolves branches in E, detects load-use hazards and counts inserted bubbles.
module control_pipeline #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUCTL_W   = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteD,
    input  logic                  ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic [ALUCTL_W-1:0]   ALUControlD,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic                  ZeroE,
    output logic                  ALUSrcE,
    output logic [ALUCTL_W-1:0]   ALUControlE,
    output logic                  PCSrcE,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [CNT_W-1:0]      BubbleCnt
);

    // E stage
    logic                  validE_q,      validE_d;
    logic                  RegWriteE_q,   RegWriteE_d;
    logic                  ResultSrcE_q,  ResultSrcE_d;
    logic                  MemWriteE_q,   MemWriteE_d;
    logic                  BranchE_q,     BranchE_d;
    logic                  ALUSrcE_q,     ALUSrcE_d;
    logic [ALUCTL_W-1:0]   ALUControlE_q, ALUControlE_d;
    logic [REG_ADDR_W-1:0] RdE_q,         RdE_d;

    // M stage
    logic                  validM_q;
    logic                  RegWriteM_q;
    logic                  ResultSrcM_q;
    logic                  MemWriteM_q;
    logic [REG_ADDR_W-1:0] RdM_q;

    // W stage
    logic                  validW_q;
    logic                  RegWriteW_q;
    logic                  ResultSrcW_q;
    logic [REG_ADDR_W-1:0] RdW_q;

    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic pcsrc;
    logic load_stall;
    logic bubble;

    always_comb begin
        pcsrc      = validE_q & BranchE_q & ZeroE;
        // Rs2D compared unconditionally: a spurious stall costs one cycle, never correctness
        load_stall = validE_q & ResultSrcE_q & RegWriteE_q & (RdE_q != '0) &
                     ((RdE_q == Rs1D) | (RdE_q == Rs2D));
        bubble     = pcsrc | load_stall;
    end

    always_comb begin
        validE_d      = 1'b0;
        RegWriteE_d   = 1'b0;
        ResultSrcE_d  = 1'b0;
        MemWriteE_d   = 1'b0;
        BranchE_d     = 1'b0;
        ALUSrcE_d     = 1'b0;
        ALUControlE_d = '0;
        RdE_d         = '0;
        if (!bubble) begin
            validE_d      = 1'b1;
            RegWriteE_d   = RegWriteD;
            ResultSrcE_d  = ResultSrcD;
            MemWriteE_d   = MemWriteD;
            BranchE_d     = BranchD;
            ALUSrcE_d     = ALUSrcD;
            ALUControlE_d = ALUControlD;
            RdE_d         = RdD;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validE_q      <= 1'b0;
            RegWriteE_q   <= 1'b0;
            ResultSrcE_q  <= 1'b0;
            MemWriteE_q   <= 1'b0;
            BranchE_q     <= 1'b0;
            ALUSrcE_q     <= 1'b0;
            ALUControlE_q <= '0;
            RdE_q         <= '0;
            validM_q      <= 1'b0;
            RegWriteM_q   <= 1'b0;
            ResultSrcM_q  <= 1'b0;
            MemWriteM_q   <= 1'b0;
            RdM_q         <= '0;
            validW_q      <= 1'b0;
            RegWriteW_q   <= 1'b0;
            ResultSrcW_q  <= 1'b0;
            RdW_q         <= '0;
            cnt_q         <= '0;
        end else begin
            validE_q      <= validE_d;
            RegWriteE_q   <= RegWriteE_d;
            ResultSrcE_q  <= ResultSrcE_d;
            MemWriteE_q   <= MemWriteE_d;
            BranchE_q     <= BranchE_d;
            ALUSrcE_q     <= ALUSrcE_d;
            ALUControlE_q <= ALUControlE_d;
            RdE_q         <= RdE_d;
            validM_q      <= validE_q;
            RegWriteM_q   <= RegWriteE_q;
            ResultSrcM_q  <= ResultSrcE_q;
            MemWriteM_q   <= MemWriteE_q;
            RdM_q         <= RdE_q;
            validW_q      <= validM_q;
            RegWriteW_q   <= RegWriteM_q;
            ResultSrcW_q  <= ResultSrcM_q;
            RdW_q         <= RdM_q;
            cnt_q         <= cnt_d;
        end
    end

    // Everything leaving a stage is gated by its valid bit so bubbles drive zeros
    assign ALUSrcE     = validE_q & ALUSrcE_q;
    assign ALUControlE = validE_q ? ALUControlE_q : '0;
    assign PCSrcE      = pcsrc;
    assign FlushD      = pcsrc;
    assign StallD      = load_stall & ~pcsrc;
    assign RegWriteM   = validM_q & RegWriteM_q;
    assign MemWriteM   = validM_q & MemWriteM_q;
    assign ResultSrcM  = validM_q & ResultSrcM_q;
    assign RdM         = validM_q ? RdM_q : '0;
    assign RegWriteW   = validW_q & RegWriteW_q;
    assign ResultSrcW  = validW_q & ResultSrcW_q;
    assign RdW         = validW_q ? RdW_q : '0;
    assign BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: expected E entries are queued as D is
// driven and compared when they reach the E, M and W outputs.
module tb_control_pipeline;

    typedef struct packed {
        logic       rw;
        logic       res;
        logic       mw;
        logic       br;
        logic       as_;
        logic [2:0] ac;
        logic [4:0] rd;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD;
    logic [2:0] ALUControlD;
    logic [4:0] RdD, Rs1D, Rs2D;
    logic       ZeroE;

    logic        ALUSrcE, PCSrcE, StallD, FlushD;
    logic [2:0]  ALUControlE;
    logic        RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW;
    logic [4:0]  RdM, RdW;
    logic [15:0] BubbleCnt;

    logic        ALUSrcE2, PCSrcE2, StallD2, FlushD2;
    logic [2:0]  ALUControlE2;
    logic        RegWriteM2, MemWriteM2, ResultSrcM2, RegWriteW2, ResultSrcW2;
    logic [4:0]  RdM2, RdW2;
    logic [1:0]  BubbleCnt2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    ent_t        q[$];
    int unsigned exp_cnt  = 0;
    int unsigned exp_cnt2 = 0;

    always #5 clk = ~clk;

    control_pipeline #(.REG_ADDR_W(5), .ALUCTL_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D), .ZeroE(ZeroE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .StallD(StallD), .FlushD(FlushD),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .BubbleCnt(BubbleCnt)
    );

    control_pipeline #(.REG_ADDR_W(5), .ALUCTL_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D), .ZeroE(ZeroE),
        .ALUSrcE(ALUSrcE2), .ALUControlE(ALUControlE2), .PCSrcE(PCSrcE2),
        .StallD(StallD2), .FlushD(FlushD2),
        .RegWriteM(RegWriteM2), .MemWriteM(MemWriteM2), .ResultSrcM(ResultSrcM2), .RdM(RdM2),
        .RegWriteW(RegWriteW2), .ResultSrcW(ResultSrcW2), .RdW(RdW2),
        .BubbleCnt(BubbleCnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic rw, input logic res, input logic mw, input logic br,
                                input logic as_, input logic [2:0] ac, input logic [4:0] rd);
        ent_t e;
        e.rw = rw; e.res = res; e.mw = mw; e.br = br; e.as_ = as_; e.ac = ac; e.rd = rd;
        return e;
    endfunction

    // After reset E, M and W all hold empty entries
    task automatic restart_scoreboard();
        q.delete();
        q.push_back('0);
        q.push_back('0);
        exp_cnt  = 0;
        exp_cnt2 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_zeros"}, {ALUSrcE, ALUControlE, PCSrcE, StallD, FlushD,
                                RegWriteM, MemWriteM, ResultSrcM, RdM,
                                RegWriteW, ResultSrcW, RdW}, 32'd0);
        check({tag, "_cnt"}, 32'(BubbleCnt), 32'd0);
        check({tag, "_cnt2"}, 32'(BubbleCnt2), 32'd0);
    endtask

    // Present one D instruction for one cycle; exp_ls/exp_pc are the hazard
    // decisions this cycle is expected to make.
    task automatic step(input ent_t d, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic zero, input logic exp_ls, input logic exp_pc);
        ent_t e;
        logic bub;
        RegWriteD = d.rw; ResultSrcD = d.res; MemWriteD = d.mw; BranchD = d.br;
        ALUSrcD = d.as_; ALUControlD = d.ac; RdD = d.rd;
        Rs1D = rs1; Rs2D = rs2; ZeroE = zero;
        #1;
        check("StallD", 32'(StallD), 32'(exp_ls & ~exp_pc));
        check("FlushD", 32'(FlushD), 32'(exp_pc));
        check("PCSrcE", 32'(PCSrcE), 32'(exp_pc));
        bub = exp_ls | exp_pc;
        e = bub ? ent_t'('0) : d;
        q.push_back(e);
        if (bub) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        @(posedge clk);
        #1;
        check("ALUSrcE", 32'(ALUSrcE), 32'(e.as_));
        check("ALUControlE", 32'(ALUControlE), 32'(e.ac));
        if (q.size() != 3) begin
            check("sb_depth", 32'(q.size()), 32'd3);
        end else begin
            check("RegWriteM", 32'(RegWriteM), 32'(q[1].rw));
            check("MemWriteM", 32'(MemWriteM), 32'(q[1].mw));
            check("ResultSrcM", 32'(ResultSrcM), 32'(q[1].res));
            check("RdM", 32'(RdM), 32'(q[1].rd));
            check("RegWriteW", 32'(RegWriteW), 32'(q[0].rw));
            check("ResultSrcW", 32'(ResultSrcW), 32'(q[0].res));
            check("RdW", 32'(RdW), 32'(q[0].rd));
            void'(q.pop_front());
        end
        check("BubbleCnt", 32'(BubbleCnt), 32'(exp_cnt));
        check("BubbleCnt2", 32'(BubbleCnt2), 32'(exp_cnt2));
    endtask

    task automatic nops(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step('0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; BranchD = 0; ALUSrcD = 0;
        ALUControlD = '0; RdD = '0; Rs1D = '0; Rs2D = '0; ZeroE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        restart_scoreboard();

        // Four independent ADDs: reach W on consecutive cycles, no hazards
        for (int unsigned i = 1; i <= 4; i++)
            step(mk(1, 0, 0, 0, 0, 3'd2, 5'(i)), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Load-use through Rs1: one stall, held ADD re-issues
        step(mk(1, 1, 0, 0, 1, 3'd0, 5'd5), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd6), 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd6), 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        // Load to x0: never stalls
        step(mk(1, 1, 0, 0, 1, 3'd0, 5'd0), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd3), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // Load-use through Rs2
        step(mk(1, 1, 0, 0, 1, 3'd0, 5'd7), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd6, 5'd8), 5'd1, 5'd7, 1'b0, 1'b1, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd6, 5'd8), 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        // Store: MemWriteM, no register write
        step(mk(0, 0, 1, 0, 1, 3'd0, 5'd0), 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);

        // Taken branch kills the next D; ZeroE on a bubble does not redirect
        step(mk(0, 0, 0, 1, 0, 3'd1, 5'd0), 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd9), 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd10), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        // Not-taken branch
        step(mk(0, 0, 0, 1, 0, 3'd1, 5'd0), 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd11), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Load-use and taken branch together: flush wins, single bubble
        step(mk(1, 1, 0, 1, 0, 3'd0, 5'd12), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd13), 5'd12, 5'd0, 1'b1, 1'b1, 1'b1);
        step(mk(1, 0, 0, 0, 0, 3'd2, 5'd14), 5'd12, 5'd0, 1'b1, 1'b0, 1'b0);
        step(mk(1, 0, 0, 0, 0, 3'd4, 5'd15), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges with instructions in flight
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        #1;
        rst = 1'b0;
        restart_scoreboard();
        step(mk(1, 0, 0, 0, 1, 3'd3, 5'd13), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        nops(3);

        // Back-to-back load chain: saturation of the 2-bit counter (1,2,3,3,3)
        step(mk(1, 1, 0, 0, 1, 3'd0, 5'd5), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int unsigned k = 0; k < 5; k++) begin
            step(mk(1, 1, 0, 0, 1, 3'd0, 5'(6 + k)), 5'(5 + k), 5'd0, 1'b0, 1'b1, 1'b0);
            step(mk(1, 1, 0, 0, 1, 3'd0, 5'(6 + k)), 5'(5 + k), 5'd0, 1'b0, 1'b0, 1'b0);
        end
        nops(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
